matrix_operand_loader: RTL and testbench

//   Upstream feeder for the 3x3 binary matrix multiplier. Collects A then B as a
//   bit-serial valid/ready stream and packs each into a 9-bit row-major word
//   (bit k = element[k/3][k%3]). Commits both words to the multiplier together.

---
 rtl/matrix_operand_loader_pkg.sv | 28 ++
 rtl/matrix_operand_loader_collector.sv | 32 +++
 rtl/matrix_operand_loader.sv | 171 +++++++++++++++++
 tb/tb_matrix_operand_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_operand_loader_pkg.sv
// Shared definitions for the 3x3 binary matrix datapath: dimensions, FSM encoding,
// and word/index types used by the loader, multiplier and output-side blocks.
package matrix_operand_loader_pkg;

  localparam int DIM   = 3;
  localparam int N     = DIM * DIM;
  localparam int IDX_W = 4;

  typedef logic [N-1:0]     word_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    PARITY,
    SETTLE,
    HOLD
  } state_t;

  // The final serial bit lands in the top element on the same edge the word is used,
  // so consumers splice it in rather than reading the shadow one cycle late.
  function automatic word_t merge_last(input word_t shadow, input logic b);
    return {b, shadow[N-2:0]};
  endfunction

endpackage

// File: rtl/matrix_operand_loader_collector.sv
// serial_shift_collector: N-bit shadow register filled one element per transfer,
// with a wrapping element index and a synchronous clear.
module serial_shift_collector
  import matrix_operand_loader_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_en,
  input  logic  in_bit,
  input  logic  clear,
  output word_t shadow,
  output logic  last
);

  idx_t idx;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      idx    <= '0;
    end else if (clear) begin
      shadow <= '0;
      idx    <= '0;
    end else if (load_en) begin
      shadow[idx] <= in_bit;
      idx         <= last ? '0 : idx + idx_t'(1);
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: packs serial A then B into row-major words, commits both to the
// multiplier together and flags the settled product. Optional parity check: LOADER_PARITY_EN.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  logic  in_bit,
  output logic  in_ready,
  input  logic  clear,
  output word_t a_out,
  output word_t b_out,
  output logic  c_valid,
  input  logic  ack,
  output logic  err
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  word_t               a_shadow;
  word_t               shadow;
  word_t               full_word;
  logic                last;
  logic                transfer;
  logic                collect_en;

  // A transfer coinciding with clear is dropped entirely.
  assign transfer   = in_valid && in_ready && !clear;
  assign collect_en = transfer && ((state == LOAD_A) || (state == LOAD_B));
  assign full_word  = merge_last(shadow, in_bit);

  serial_shift_collector u_collector (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (collect_en),
    .in_bit  (in_bit),
    .clear   (clear),
    .shadow  (shadow),
    .last    (last)
  );

`ifdef LOADER_PARITY_EN
  logic  par_acc;
  logic  err_q;
  word_t b_shadow;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      settle_cnt <= '0;
      a_shadow   <= '0;
      a_out      <= '0;
      b_out      <= '0;
      c_valid    <= 1'b0;
      in_ready   <= 1'b0;
`ifdef LOADER_PARITY_EN
      par_acc    <= 1'b0;
      err_q      <= 1'b0;
      b_shadow   <= '0;
`endif
    end else begin
`ifdef LOADER_PARITY_EN
      err_q <= 1'b0;
`endif
      if (clear) begin
        state      <= LOAD_A;
        settle_cnt <= '0;
        c_valid    <= 1'b0;
        in_ready   <= 1'b1;
`ifdef LOADER_PARITY_EN
        par_acc    <= 1'b0;
`endif
      end else begin
        case (state)
          LOAD_A: begin
            in_ready <= 1'b1;
            if (transfer) begin
`ifdef LOADER_PARITY_EN
              par_acc <= par_acc ^ in_bit;
`endif
              if (last) begin
                a_shadow <= full_word;
                state    <= LOAD_B;
              end
            end
          end

          LOAD_B: begin
            in_ready <= 1'b1;
            if (transfer) begin
`ifdef LOADER_PARITY_EN
              par_acc <= par_acc ^ in_bit;
              if (last) begin
                b_shadow <= full_word;
                state    <= PARITY;
              end
`else
              if (last) begin
                a_out      <= a_shadow;
                b_out      <= full_word;
                settle_cnt <= '0;
                in_ready   <= 1'b0;
                state      <= SETTLE;
              end
`endif
            end
          end

          PARITY: begin
`ifdef LOADER_PARITY_EN
            in_ready <= 1'b1;
            if (transfer) begin
              par_acc <= 1'b0;
              // Even total weight over 18 data bits plus this bit means a clean load.
              if ((par_acc ^ in_bit) == 1'b0) begin
                a_out      <= a_shadow;
                b_out      <= b_shadow;
                settle_cnt <= '0;
                in_ready   <= 1'b0;
                state      <= SETTLE;
              end else begin
                err_q <= 1'b1;
                state <= LOAD_A;
              end
            end
`else
            in_ready <= 1'b1;
            state    <= LOAD_A;
`endif
          end

          SETTLE: begin
            in_ready <= 1'b0;
            if (settle_cnt == SETTLE_LAST) begin
              c_valid <= 1'b1;
              state   <= HOLD;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end

          HOLD: begin
            in_ready <= 1'b0;
            if (ack) begin
              c_valid  <= 1'b0;
              in_ready <= 1'b1;
              state    <= LOAD_A;
            end
          end

          default: begin
            state    <= LOAD_A;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: table of matrix pairs plus hand sequences for clear,
// reset and handshake corners; expected products come from a reference 3x3 multiply.
module tb_matrix_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       clear;
  logic [8:0] a_out;
  logic [8:0] b_out;
  logic       c_valid;
  logic       ack;
  logic       err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [8:0]  a;
    logic [8:0]  b;
    logic [17:0] c;
    bit          gaps;
    bit          ack_in_settle;
    int          hold_idle;
  } vec_t;

  typedef struct {
    logic [8:0]  a;
    logic [8:0]  b;
    logic [17:0] c;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .clear    (clear),
    .a_out    (a_out),
    .b_out    (b_out),
    .c_valid  (c_valid),
    .ack      (ack),
    .err      (err)
  );

  // Reference integer product of two binary matrices, 2 bits per element, row-major.
  function automatic logic [17:0] matmul(input logic [8:0] a, input logic [8:0] b);
    logic [17:0] c;
    c = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(a[i*3+k] & b[k*3+j]);
        c[2*(i*3+j) +: 2] = 2'(s);
      end
    end
    return c;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_bit(input logic b, input bit gaps, inout int ready_drops);
    bit accepted;
    int waited;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_bit   = b;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 50) begin
      accepted = in_ready;
      if (!in_ready) ready_drops++;
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    if (!accepted) check_output("transfer_accepted", 32'(accepted), 1);
  endtask

  task automatic load_words(input logic [8:0] a, input logic [8:0] b, input bit gaps,
                            input bit flip_parity, inout int drops);
    for (int k = 0; k < 9; k++) send_bit(a[k], gaps, drops);
    for (int k = 0; k < 9; k++) send_bit(b[k], gaps, drops);
`ifdef LOADER_PARITY_EN
    send_bit((^{a, b}) ^ flip_parity, gaps, drops);
`else
    if (flip_parity) drops += 0;
`endif
  endtask

  task automatic check_result();
    exp_t e;
    if (sb.size() == 0) begin
      check_output("scoreboard_nonempty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check_output("sb_a_out", a_out, e.a);
      check_output("sb_b_out", b_out, e.b);
      check_output("sb_product", matmul(a_out, b_out), e.c);
    end
  endtask

  task automatic wait_settle(input bit ack_early);
    int cycles;
    ack    = ack_early;
    cycles = 0;
    while (!c_valid && cycles < 20) begin
      @(negedge clk);
      ack = 1'b0;
      cycles++;
    end
    check_output("settle_latency", cycles, 2);
  endtask

  task automatic apply_stimulus(input vec_t v);
    int drops;
    int lows;
    drops = 0;
    sb.push_back('{a: v.a, b: v.b, c: v.c});
    load_words(v.a, v.b, v.gaps, 1'b0, drops);
    check_output("in_ready_during_load", drops, 0);
    check_output("a_out_commit", a_out, v.a);
    check_output("b_out_commit", b_out, v.b);
    check_output("c_valid_at_commit", c_valid, 0);
    check_output("in_ready_at_commit", in_ready, 0);
    check_output("err_at_commit", err, 0);
    wait_settle(v.ack_in_settle);
    check_result();
    lows = 0;
    repeat (v.hold_idle) begin
      @(negedge clk);
      if (!c_valid) lows++;
    end
    check_output("c_valid_hold", lows, 0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_output("c_valid_after_ack", c_valid, 0);
    check_output("in_ready_after_ack", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   drops;
    logic [8:0] keep_a, keep_b;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
    ack      = 1'b0;

    vecs[0] = '{a: 9'b111_010_101, b: 9'b011_110_011, c: 18'b01_11_10_01_01_00_00_10_10,
                gaps: 1'b0, ack_in_settle: 1'b0, hold_idle: 7};
    vecs[1] = '{a: 9'(($urandom)), b: 9'(($urandom)), c: '0,
                gaps: 1'b1, ack_in_settle: 1'b1, hold_idle: 1};
    vecs[2] = '{a: 9'h1FF, b: 9'h1FF, c: 18'h3FFFF,
                gaps: 1'b1, ack_in_settle: 1'b0, hold_idle: 0};
    vecs[3] = '{a: 9'h000, b: 9'h155, c: 18'h00000,
                gaps: 1'b0, ack_in_settle: 1'b0, hold_idle: 2};
    vecs[4] = '{a: 9'h0A3, b: 9'h13C, c: '0,
                gaps: 1'b1, ack_in_settle: 1'b1, hold_idle: 3};
    vecs[1].c = matmul(vecs[1].a, vecs[1].b);
    vecs[4].c = matmul(vecs[4].a, vecs[4].b);

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("reset_a_out", a_out, 0);
    check_output("reset_b_out", b_out, 0);
    check_output("reset_c_valid", c_valid, 0);
    check_output("reset_err", err, 0);
    check_output("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_output("in_ready_before_first_clock", in_ready, 0);
    @(negedge clk);
    check_output("in_ready_after_release", in_ready, 1);

    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

    // Clear part-way through A: old words stay, next load restarts at element 0.
    keep_a = vecs[4].a;
    keep_b = vecs[4].b;
    drops  = 0;
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0, drops);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check_output("clear_in_ready", in_ready, 1);
    check_output("clear_c_valid", c_valid, 0);
    check_output("clear_keeps_a", a_out, keep_a);
    check_output("clear_keeps_b", b_out, keep_b);
    v = '{a: 9'b000_110_010, b: 9'b101_001_100, c: '0,
          gaps: 1'b0, ack_in_settle: 1'b0, hold_idle: 0};
    v.c = matmul(v.a, v.b);
    apply_stimulus(v);

    // clear together with ack while holding: c_valid drops, words retained.
    v = '{a: 9'h0F0, b: 9'h00F, c: '0, gaps: 1'b0, ack_in_settle: 1'b0, hold_idle: 0};
    v.c = matmul(v.a, v.b);
    sb.push_back('{a: v.a, b: v.b, c: v.c});
    drops = 0;
    load_words(v.a, v.b, 1'b0, 1'b0, drops);
    wait_settle(1'b0);
    check_result();
    clear = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ack   = 1'b0;
    check_output("clear_ack_c_valid", c_valid, 0);
    check_output("clear_ack_in_ready", in_ready, 1);
    check_output("clear_ack_keeps_a", a_out, v.a);

    // Asynchronous reset mid-load: outputs zero at once, no partial commit.
    drops = 0;
    for (int k = 0; k < 10; k++) send_bit(k[0], 1'b0, drops);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midload_reset_a_out", a_out, 0);
    check_output("midload_reset_b_out", b_out, 0);
    check_output("midload_reset_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("midload_release_in_ready", in_ready, 1);
    v = '{a: 9'h1A5, b: 9'h05A, c: '0, gaps: 1'b1, ack_in_settle: 1'b0, hold_idle: 1};
    v.c = matmul(v.a, v.b);
    apply_stimulus(v);

`ifdef LOADER_PARITY_EN
    // Wrong parity bit: one-cycle err, no commit, back to loading A.
    keep_a = v.a;
    keep_b = v.b;
    drops  = 0;
    load_words(9'h111, 9'h0C3, 1'b0, 1'b1, drops);
    check_output("parity_err_pulse", err, 1);
    check_output("parity_err_keeps_a", a_out, keep_a);
    check_output("parity_err_keeps_b", b_out, keep_b);
    check_output("parity_err_in_ready", in_ready, 1);
    @(negedge clk);
    check_output("parity_err_one_cycle", err, 0);
    v = '{a: 9'h111, b: 9'h0C3, c: '0, gaps: 1'b0, ack_in_settle: 1'b0, hold_idle: 0};
    v.c = matmul(v.a, v.b);
    apply_stimulus(v);
`endif

    check_output("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
